stopwatch_display: RTL and testbench
====================================

STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clocks per digit period (1 kHz per digit at 100 MHz); SHALL be >= BLANK_CYCLES+2.
REQ-002 Parameter: BLANK_CYCLES, default 1000, clocks at the start of each digit period with all anodes off (anti-ghosting); 0 permitted.
REQ-003 Port: clk, input, 1, system clock, all logic on rising edge.
REQ-004 Port: reset, input, 1, synchronous, active-high.
REQ-005 Port: minutes, input, 4, BCD minutes digit from the stopwatch.
REQ-006 Port: tens_seconds, input, 4, BCD tens-of-seconds digit.
REQ-007 Port: ones_seconds, input, 4, BCD ones-of-seconds digit.
REQ-008 Port: tenths_seconds, input, 4, BCD tenths digit.
REQ-009 Port: update, input, 1, single-cycle strobe that captures all four digits into the snapshot.
REQ-010 Port: enable, input, 1, 1 = scan the display, 0 = display dark.
REQ-011 Port: blank_lz, input, 1, 1 = blank the minutes digit when its snapshot is 0.
REQ-012 Port: an, output, 4, active-low anodes; an[0] = tenths (rightmost), an[3] = minutes.
REQ-013 Port: seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-014 Port: dp, output, 1, active-low decimal point.

Function
REQ-015 Snapshot: on a cycle with update=1, all four inputs SHALL be latched together the following edge; no partial capture; with update=0 the snapshot SHALL hold.
REQ-016 Refresh counter cnt SHALL count 0..REFRESH_DIV-1 and wrap; at the wrap, digit index idx SHALL advance 0->1->2->3->0.
REQ-017 idx mapping: 0 = tenths, 1 = ones_seconds, 2 = tens_seconds, 3 = minutes.
REQ-018 While cnt < BLANK_CYCLES: an=4'b1111, seg=7'b1111111, dp=1.
REQ-019 While cnt >= BLANK_CYCLES: exactly one an bit SHALL be low (an[idx]); seg SHALL be the decode of the snapshot digit selected by idx.
REQ-020 Decode: values 0-9 use the standard 7-segment pattern (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000); values 10-15 SHALL show a dash (7'b0111111).
REQ-021 dp SHALL be low when idx=1 (seconds.tenths separator) and when idx=3 (minutes separator); otherwise high.
REQ-022 Leading-zero blank: when blank_lz=1, idx=3 and snapshot minutes=0, seg=7'b1111111 and dp=1; the anode timing is unchanged.
REQ-023 an, seg and dp SHALL be registered; each output reflects cnt/idx/snapshot of the previous cycle (1-cycle latency).
REQ-024 A snapshot change SHALL appear at the next active cycle of the affected digit; the scan SHALL NOT restart.
REQ-025 enable=0: cnt and idx SHALL be held at 0 and outputs SHALL be dark (an=1111, seg=1111111, dp=1); update capture SHALL still operate.
REQ-026 On enable 0->1, the scan SHALL start at cnt=0, idx=0.
REQ-027 update and the refresh wrap in the same cycle: both SHALL take effect; the new idx SHALL display the new snapshot.

Reset
REQ-028 reset=1 SHALL set cnt=0, idx=0, all snapshot digits=0, an=4'b1111, seg=7'b1111111, dp=1 on the next edge; this SHALL override update and enable.
REQ-029 Reset asserted mid-scan SHALL abort the current digit period; after reset release the scan SHALL resume at idx=0, cnt=0.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-030 Reset, then enable=1 with no update -> an cycles 1110,1101,1011,0111 at 8-cycle spacing; each period is dark for 2 cycles; seg=1000000 on every digit; dp low on an[1] and an[3].
REQ-031 Digits 3,5,9,7 (m,ts,os,t) with an update pulse, blank_lz=0 -> an[0] shows 7, an[1] shows 9 with dp low, an[2] shows 5, an[3] shows 3 with dp low.
REQ-032 Inputs changed without an update pulse -> display unchanged; a single update pulse -> all four digits change together at their next slots.
REQ-033 minutes=0 with blank_lz=1 -> during the an[3] active window, seg=1111111 and dp=1; with blank_lz=0 it shows 0 and dp is low.
REQ-034 tens_seconds=4'hB captured -> the an[2] slot shows seg=0111111 (dash).
REQ-035 reset pulsed during the idx=2 active window -> next cycle all outputs are dark and the snapshot is 0; the scan restarts at an=1110 after 2 dark cycles; enable=0 -> outputs stay dark indefinitely.

Source files
------------

// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_display
// Description : Four-digit multiplexed 7-segment driver for a stopwatch
//               (M.SS.T).  It captures a snapshot of the digits on an
//               update strobe, scans the digits with an anti-ghosting blank
//               at the start of each digit period, and can blank a leading
//               zero on the minutes digit.  All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] minutes,
    input  logic [3:0] tens_seconds,
    input  logic [3:0] ones_seconds,
    input  logic [3:0] tenths_seconds,
    input  logic       update,
    input  logic       enable,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int                 c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK = c_CNT_W'(BLANK_CYCLES);
    localparam logic [6:0]         c_DARK  = 7'b1111111;
    localparam logic [6:0]         c_DASH  = 7'b0111111;

    // Snapshot packed as {minutes, tens, ones, tenths} so idx selects nibble idx.
    logic [15:0]        r_snap;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_idx;

    logic [3:0]         w_digit;
    logic [6:0]         w_seg_dec;
    logic               w_blank_min;

    // Capture all four digits together on the update strobe, independent of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap <= 16'h0000;
        end else if (update) begin
            r_snap <= {minutes, tens_seconds, ones_seconds, tenths_seconds};
        end
    end

    // Refresh counter and digit index; held at the scan origin while disabled.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_digit     = r_snap[{r_idx, 2'b00} +: 4];
    assign w_blank_min = blank_lz && (r_idx == 2'd3) && (w_digit == 4'd0);

    // Active-low 7-segment decode {g,f,e,d,c,b,a}; non-BCD values show a dash.
    always_comb begin
        w_seg_dec = c_DASH;
        case (w_digit)
            4'd0: w_seg_dec = 7'b1000000;
            4'd1: w_seg_dec = 7'b1111001;
            4'd2: w_seg_dec = 7'b0100100;
            4'd3: w_seg_dec = 7'b0110000;
            4'd4: w_seg_dec = 7'b0011001;
            4'd5: w_seg_dec = 7'b0010010;
            4'd6: w_seg_dec = 7'b0000010;
            4'd7: w_seg_dec = 7'b1111000;
            4'd8: w_seg_dec = 7'b0000000;
            4'd9: w_seg_dec = 7'b0010000;
            default: w_seg_dec = c_DASH;
        endcase
    end

    // Register the display outputs from this cycle's scan position and snapshot.
    always_ff @(posedge clk) begin
        if (reset || !enable || (r_cnt < c_BLANK)) begin
            an  <= 4'b1111;
            seg <= c_DARK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << r_idx);
            seg <= w_blank_min ? c_DARK : w_seg_dec;
            // Separator dots sit after the minutes and after the ones-of-seconds.
            dp  <= w_blank_min ? 1'b1 : ~r_idx[0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_display
// Description : Self-checking bench for stopwatch_display with a small
//               scan-position reference model (REFRESH_DIV=8, BLANK_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_display;

    localparam int c_DIV   = 8;
    localparam int c_BLANK = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] minutes = 4'd0;
    logic [3:0] tens_seconds = 4'd0;
    logic [3:0] ones_seconds = 4'd0;
    logic [3:0] tenths_seconds = 4'd0;
    logic       update = 1'b0;
    logic       enable = 1'b0;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    stopwatch_display #(
        .REFRESH_DIV  (c_DIV),
        .BLANK_CYCLES (c_BLANK)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .minutes        (minutes),
        .tens_seconds   (tens_seconds),
        .ones_seconds   (ones_seconds),
        .tenths_seconds (tenths_seconds),
        .update         (update),
        .enable         (enable),
        .blank_lz       (blank_lz),
        .an             (an),
        .seg            (seg),
        .dp             (dp)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed enabled cycles since scan start plus the snapshot.
    int         m_t;
    logic [3:0] m_snap [4];
    logic [6:0] seg_tab [16];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%b expected=%b (t=%0d)", tag, obs, exp, m_t);
    endtask

    task automatic set_digits(input logic [3:0] m, input logic [3:0] ts,
                              input logic [3:0] os, input logic [3:0] t);
        minutes        = m;
        tens_seconds   = ts;
        ones_seconds   = os;
        tenths_seconds = t;
    endtask

    // One clock: predict outputs, advance the model with the applied inputs, then compare.
    task automatic tick();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         pos;
        int         dig;
        e_an  = 4'b1111;
        e_seg = 7'b1111111;
        e_dp  = 1'b1;
        if (!reset && enable) begin
            pos = m_t % c_DIV;
            dig = (m_t / c_DIV) % 4;
            if (pos >= c_BLANK) begin
                e_an      = 4'b1111;
                e_an[dig] = 1'b0;
                if (blank_lz && dig == 3 && m_snap[3] == 4'd0) begin
                    e_seg = 7'b1111111;
                    e_dp  = 1'b1;
                end else begin
                    e_seg = seg_tab[m_snap[dig]];
                    e_dp  = (dig == 1 || dig == 3) ? 1'b0 : 1'b1;
                end
            end
        end
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;
        end else if (update) begin
            m_snap[0] = tenths_seconds;
            m_snap[1] = ones_seconds;
            m_snap[2] = tens_seconds;
            m_snap[3] = minutes;
        end
        m_t = (reset || !enable) ? 0 : m_t + 1;
        #1;
        chk("an",  {3'b000, an},  {3'b000, e_an});
        chk("seg", seg,           e_seg);
        chk("dp",  {6'b0, dp},    {6'b0, e_dp});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        for (int k = 10; k < 16; k++) seg_tab[k] = 7'b0111111;
        m_t = 0;
        for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;

        // Reset with update and enable asserted: reset must win.
        update = 1'b1;
        enable = 1'b1;
        set_digits(4'd6, 4'd6, 4'd6, 4'd6);
        @(negedge clk);
        run(3);
        reset  = 1'b0;
        update = 1'b0;

        // Full scan of the reset snapshot (all zeros).
        run(40);

        // Load 3,5,9,7 and scan.
        set_digits(4'd3, 4'd5, 4'd9, 4'd7);
        pulse_update();
        run(36);

        // Inputs change without update: display holds; then one update.
        set_digits(4'd1, 4'd2, 4'd4, 4'd8);
        run(32);
        pulse_update();
        run(32);

        // Minutes leading zero, blanked then shown.
        set_digits(4'd0, 4'd4, 4'd2, 4'd6);
        blank_lz = 1'b1;
        pulse_update();
        run(32);
        blank_lz = 1'b0;
        run(32);

        // Non-BCD tens-of-seconds shows a dash.
        set_digits(4'd2, 4'hB, 4'd0, 4'd1);
        pulse_update();
        run(32);

        // Update coinciding with a refresh wrap.
        for (int k = 0; k < 16 && (m_t % c_DIV) != c_DIV - 1; k++) tick();
        set_digits(4'd9, 4'd8, 4'd7, 4'd6);
        pulse_update();
        run(16);

        // Randomized operation.
        for (int k = 0; k < 800; k++) begin
            set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) minutes = 4'd0;
            update = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
            reset = ($urandom_range(0, 127) == 0);
            tick();
        end
        update = 1'b0;
        reset  = 1'b0;
        enable = 1'b1;
        blank_lz = 1'b0;
        run(8);

        // Reset in the middle of the idx=2 active window, then scan restarts.
        set_digits(4'd5, 4'd5, 4'd5, 4'd5);
        pulse_update();
        for (int k = 0; k < 64 && !(((m_t / c_DIV) % 4) == 2 && (m_t % c_DIV) == 4); k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(40);

        // Disabled: dark indefinitely, capture still works.
        enable = 1'b0;
        set_digits(4'd4, 4'd3, 4'd2, 4'd1);
        pulse_update();
        run(30);
        enable = 1'b1;
        run(36);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
